ps_setpoint_collector: RTL

Receives the floating-point power-supply setpoint AXI stream produced by the setpoint calculator, one frame of RESULT_COUNT words per FOFB cycle. It validates frame length against TLAST and stores complete frames in a double-buffered bank. It exposes the most recent good frame through a registered random-access read port and reports frame-arrival and framing-error status to the CSR layer. It sits between the setpoint pipeline and the power-supply link transmitters / diagnostic readback.

---
 rtl/ps_setpoint_collector_pkg.sv | 24 ++
 rtl/ps_setpoint_collector_bank_ram.sv | 34 +++
 rtl/ps_setpoint_collector.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ps_setpoint_collector_pkg.sv
// Shared definitions for the setpoint collector: status bit map, framing FSM
// encoding and the optional statistics field layout.
package ps_setpoint_collector_pkg;

  typedef enum logic [0:0] {
    STATE_COLLECT = 1'b0,
    STATE_DROP    = 1'b1
  } state_t;

  localparam int STATUS_SHORT_BIT = 0;
  localparam int STATUS_LONG_BIT  = 1;
  localparam int STATUS_HAVE_BIT  = 2;

  localparam int STATS_FIELD_LSB     = 16;
  localparam int STATS_FIELD_WIDTH   = 16;
  localparam int STATS_ERR_CNT_LSB   = 16;
  localparam int STATS_FRAME_CNT_LSB = 24;
  localparam int STATS_CNT_WIDTH     = 8;

  function automatic logic [STATS_CNT_WIDTH-1:0] sat_inc(input logic [STATS_CNT_WIDTH-1:0] v);
    return (v == {STATS_CNT_WIDTH{1'b1}}) ? v : v + STATS_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/ps_setpoint_collector_bank_ram.sv
// Double-bank setpoint storage: simple dual-port RAM addressed as {bank, index},
// synchronous write and registered read port.
module psSetpointBankRam #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Full power-of-two depth: {bank, index} leaves holes when the frame length
  // is not a power of two.
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ps_setpoint_collector.sv
// Collects setpoint frames from the AXI stream into a double-buffered bank.
// Optional statistics counters in status[31:16]: PS_SETPOINT_COLLECTOR_STATS_EN.
//
// state         | meaning
// STATE_COLLECT | storing beats of the current frame into the write bank
// STATE_DROP    | frame overran RESULT_COUNT; discard beats until TLAST
module ps_setpoint_collector
  import ps_setpoint_collector_pkg::*;
#(
  parameter int RESULT_COUNT       = 24,
  parameter int FLOAT_WIDTH        = 32,
  parameter int DBUS_WIDTH         = 32,
  parameter int RESULT_COUNT_WIDTH = (RESULT_COUNT == 1) ? 1 : $clog2(RESULT_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          SETPOINT_TVALID,
  input  logic                          SETPOINT_TLAST,
  input  logic [FLOAT_WIDTH-1:0]        SETPOINT_TDATA,
  input  logic [RESULT_COUNT_WIDTH-1:0] readAddress,
  output logic [FLOAT_WIDTH-1:0]        readData,
  output logic                          frameToggle,
  input  logic                          statusClearStrobe,
  output logic [DBUS_WIDTH-1:0]         status
);

  localparam logic [RESULT_COUNT_WIDTH-1:0] LAST_INDEX = RESULT_COUNT_WIDTH'(RESULT_COUNT - 1);

  state_t                        state_q;
  state_t                        state_d;
  logic [RESULT_COUNT_WIDTH-1:0] wr_index_q;
  logic                          read_bank_q;
  logic                          frame_toggle_q;
  logic                          short_q;
  logic                          long_q;
  logic                          have_q;
  logic                          at_last;
  logic                          wr_en;
  logic                          commit;
  logic                          set_short;
  logic                          set_long;
  logic                          index_inc;
  logic                          index_clear;
  logic [STATS_FIELD_WIDTH-1:0]  stats_field;

  assign at_last = (wr_index_q == LAST_INDEX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STATE_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (SETPOINT_TVALID) begin
      case (state_q)
        STATE_COLLECT: if (!SETPOINT_TLAST && at_last) state_d = STATE_DROP;
        STATE_DROP:    if (SETPOINT_TLAST) state_d = STATE_COLLECT;
        default:       state_d = STATE_COLLECT;
      endcase
    end
  end

  always_comb begin
    wr_en       = 1'b0;
    commit      = 1'b0;
    set_short   = 1'b0;
    set_long    = 1'b0;
    index_inc   = 1'b0;
    index_clear = 1'b0;
    if (SETPOINT_TVALID) begin
      case (state_q)
        STATE_COLLECT: begin
          if (SETPOINT_TLAST) begin
            index_clear = 1'b1;
            if (at_last) begin
              wr_en  = 1'b1;
              commit = 1'b1;
            end else begin
              set_short = 1'b1;
            end
          end else begin
            wr_en = 1'b1;
            if (at_last) begin
              set_long = 1'b1;
            end else begin
              index_inc = 1'b1;
            end
          end
        end
        STATE_DROP: index_clear = SETPOINT_TLAST;
        default:    index_clear = 1'b1;
      endcase
    end
  end

  // Set beats clear on the sticky error bits so a coincident error is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_index_q     <= '0;
      read_bank_q    <= 1'b0;
      frame_toggle_q <= 1'b0;
      short_q        <= 1'b0;
      long_q         <= 1'b0;
      have_q         <= 1'b0;
    end else begin
      if (index_clear) begin
        wr_index_q <= '0;
      end else if (index_inc) begin
        wr_index_q <= wr_index_q + RESULT_COUNT_WIDTH'(1);
      end
      if (commit) begin
        read_bank_q    <= ~read_bank_q;
        frame_toggle_q <= ~frame_toggle_q;
        have_q         <= 1'b1;
      end
      short_q <= set_short | (short_q & ~statusClearStrobe);
      long_q  <= set_long | (long_q & ~statusClearStrobe);
    end
  end

`ifdef PS_SETPOINT_COLLECTOR_STATS_EN
  logic [STATS_CNT_WIDTH-1:0] frame_cnt_q;
  logic [STATS_CNT_WIDTH-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (commit) begin
        frame_cnt_q <= frame_cnt_q + STATS_CNT_WIDTH'(1);
      end
      if (set_short || set_long) begin
        err_cnt_q <= statusClearStrobe ? STATS_CNT_WIDTH'(1) : sat_inc(err_cnt_q);
      end else if (statusClearStrobe) begin
        err_cnt_q <= '0;
      end
    end
  end

  assign stats_field = {frame_cnt_q, err_cnt_q};
`else
  assign stats_field = '0;
`endif

  always_comb begin
    status                                         = '0;
    status[STATUS_SHORT_BIT]                       = short_q;
    status[STATUS_LONG_BIT]                        = long_q;
    status[STATUS_HAVE_BIT]                        = have_q;
    status[STATS_FIELD_LSB +: STATS_FIELD_WIDTH]   = stats_field;
  end

  assign frameToggle = frame_toggle_q;

  psSetpointBankRam #(
    .DATA_WIDTH (FLOAT_WIDTH),
    .ADDR_WIDTH (RESULT_COUNT_WIDTH + 1)
  ) u_bank_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr ({~read_bank_q, wr_index_q}),
    .wr_data (SETPOINT_TDATA),
    .rd_addr ({read_bank_q, readAddress}),
    .rd_data (readData)
  );

endmodule
